// File: rtl/keccak_rate_packer.sv
// keccak_rate_packer
//   Packs 32-bit cust5 message words (HEAD / DATA / TAIL) into SHA3-512 rate
//   blocks (RATE_WORDS x 32 bits) with SHA3 padding (0x06 .. 0x80). Each block
//   is offered to the Keccak-f[1600] core over a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_in_valid/o_in_ready message word handshake
//   i_in_data             word; [31:24] is the earliest message byte
//   i_in_head, i_in_last  first / final word of a message
//   i_in_bytes            valid bytes of a final word (0..4, >4 means 4)
//   o_blk_valid/i_blk_ready  rate block handshake
//   o_blk_data            block, message byte i at [8i+7:8i]
//   o_blk_first/o_blk_last   block is first / final of its message
//   o_err                 sticky: non-head word seen while idle
module keccak_rate_packer #(
  parameter int RATE_WORDS = 18
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [31:0]                i_in_data,
  input  logic                       i_in_head,
  input  logic                       i_in_last,
  input  logic [2:0]                 i_in_bytes,
  output logic                       o_blk_valid,
  input  logic                       i_blk_ready,
  output logic [RATE_WORDS*32-1:0]   o_blk_data,
  output logic                       o_blk_first,
  output logic                       o_blk_last,
  output logic                       o_err
);

  localparam int RB = RATE_WORDS * 4;          // bytes per block
  localparam int BW = RATE_WORDS * 32;         // bits per block
  localparam int CW = $clog2(RATE_WORDS + 1);  // word counter width
  localparam int NW = $clog2(RB + 1);          // byte count width

  // Standalone pad block used when the message ended exactly on a block edge.
  localparam logic [BW-1:0] PAD_BLK = {8'h80, {(BW-16){1'b0}}, 8'h06};

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

  state_t          r_state, w_state;
  logic [BW-1:0]   r_buf, w_buf, w_wr_buf;
  logic [CW-1:0]   r_cnt, w_cnt, w_cnt_base;
  logic            r_pad_pend, w_pad_pend;
  logic            r_first_pend, w_first_pend;
  logic            r_last, w_last;
  logic            r_err, w_err;
  logic [2:0]      w_nbytes;
  logic [NW-1:0]   w_n;

  assign o_in_ready  = (r_state != S_FULL);
  assign o_blk_valid = (r_state == S_FULL);
  assign o_blk_data  = r_buf;
  assign o_blk_first = o_blk_valid & r_first_pend;
  assign o_blk_last  = o_blk_valid & r_last;
  assign o_err       = r_err;

  // A head word restarts the block, so it lands at word 0 of a cleared buffer.
  assign w_cnt_base = i_in_head ? '0 : r_cnt;
  assign w_nbytes   = !i_in_last ? 3'd4 : (i_in_bytes > 3'd4) ? 3'd4 : i_in_bytes;
  assign w_n        = NW'({w_cnt_base, 2'b00}) + NW'(w_nbytes);

  // Buffer image after writing the incoming word (byte-swapped into Keccak
  // little-endian order) and, for a short final word, the SHA3 pad bits.
  always_comb begin
    w_wr_buf = i_in_head ? '0 : r_buf;
    for (int i = 0; i < RB; i++) begin
      if ((i / 4) == int'(w_cnt_base) && (i % 4) < int'(w_nbytes))
        w_wr_buf[8*i +: 8] = i_in_data[31-8*(i%4) -: 8];
      if (i_in_last && w_n < NW'(RB) && i == int'(w_n))
        w_wr_buf[8*i +: 8] = w_wr_buf[8*i +: 8] | 8'h06;
    end
    // n = RB-1 puts both pad markers in the top byte, giving 0x86.
    if (i_in_last && w_n < NW'(RB))
      w_wr_buf[BW-1 -: 8] = w_wr_buf[BW-1 -: 8] | 8'h80;
  end

  always_comb begin
    w_state      = r_state;
    w_buf        = r_buf;
    w_cnt        = r_cnt;
    w_pad_pend   = r_pad_pend;
    w_first_pend = r_first_pend;
    w_last       = r_last;
    w_err        = r_err;
    case (r_state)
      S_IDLE, S_FILL: begin
        if (i_in_valid) begin
          if (r_state == S_IDLE && !i_in_head) begin
            w_err = 1'b1;                      // stray word, dropped
          end else begin
            if (i_in_head) begin
              w_err        = 1'b0;
              w_first_pend = 1'b1;
              w_pad_pend   = 1'b0;
            end
            w_buf   = w_wr_buf;
            w_cnt   = w_cnt_base + 1'b1;
            w_state = S_FILL;
            if (i_in_last) begin
              w_state = S_FULL;
              // Message filled the block exactly: padding goes in a block of its own.
              if (w_n == NW'(RB)) begin
                w_last     = 1'b0;
                w_pad_pend = 1'b1;
              end else begin
                w_last = 1'b1;
              end
            end else if (w_cnt_base == CW'(RATE_WORDS - 1)) begin
              w_state = S_FULL;
              w_last  = 1'b0;
            end
          end
        end
      end
      S_FULL: begin
        if (i_blk_ready) begin
          w_first_pend = 1'b0;
          if (r_pad_pend) begin
            w_buf      = PAD_BLK;
            w_pad_pend = 1'b0;
            w_last     = 1'b1;
          end else if (r_last) begin
            w_state = S_IDLE;
            w_last  = 1'b0;
          end else begin
            w_buf   = '0;
            w_cnt   = '0;
            w_state = S_FILL;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_pad_pend   <= 1'b0;
      r_first_pend <= 1'b0;
      r_last       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_buf        <= w_buf;
      r_cnt        <= w_cnt;
      r_pad_pend   <= w_pad_pend;
      r_first_pend <= w_first_pend;
      r_last       <= w_last;
      r_err        <= w_err;
    end
  end

endmodule

// File: tb/tb_keccak_rate_packer.sv
// Bench for keccak_rate_packer: message-level reference model (byte queues and
// a queue of expected blocks), checked every cycle, plus directed literal checks.
module tb_keccak_rate_packer;
  localparam int RB = 72;
  localparam int BW = 576;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_head = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
  logic [31:0]   in_data = '0;
  logic [2:0]    in_bytes = '0;
  logic          o_in_ready, o_blk_valid, o_blk_first, o_blk_last, o_err;
  logic [BW-1:0] o_blk_data;

  always #5 clk = ~clk;

  keccak_rate_packer #(.RATE_WORDS(18)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_in_data(in_data), .i_in_head(in_head), .i_in_last(in_last), .i_in_bytes(in_bytes),
    .o_blk_valid(o_blk_valid), .i_blk_ready(blk_ready), .o_blk_data(o_blk_data),
    .o_blk_first(o_blk_first), .o_blk_last(o_blk_last), .o_err(o_err)
  );

  typedef struct {logic [BW-1:0] d; bit f; bit l;} blk_t;
  blk_t         q[$];      // expected blocks not yet consumed
  blk_t         cap[$];    // blocks actually handed over
  byte unsigned cur[$];    // message bytes of the block being filled
  bit           m_act, mfirst, merr;
  int           n_cmp = 0, n_bad = 0;
  int           rmode = 1; // 0 random blk_ready, 1 always, 2 never

  task automatic chk(input string nm, input logic [BW-1:0] a, input logic [BW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  function automatic void emit(bit last);
    blk_t b;
    int   n;
    b.d = '0;
    n   = cur.size();
    foreach (cur[i]) b.d[8*i +: 8] = cur[i];
    if (last) begin
      b.d[8*n +: 8]  = b.d[8*n +: 8] | 8'h06;
      b.d[BW-1 -: 8] = b.d[BW-1 -: 8] | 8'h80;
    end
    b.f = mfirst;
    b.l = last;
    q.push_back(b);
    mfirst = 1'b0;
    cur.delete();
  endfunction

  function automatic void model_word();
    int nb;
    if (in_head) begin
      cur.delete();
      m_act  = 1'b1;
      mfirst = 1'b1;
      merr   = 1'b0;
    end else if (!m_act) begin
      merr = 1'b1;
      return;
    end
    nb = !in_last ? 4 : (in_bytes > 3'd4) ? 4 : int'(in_bytes);
    for (int k = 0; k < nb; k++) cur.push_back(in_data[31-8*k -: 8]);
    if (in_last) begin
      if (cur.size() == RB) emit(1'b0);
      emit(1'b1);
      m_act = 1'b0;
    end else if (cur.size() == RB) begin
      emit(1'b0);
    end
  endfunction

  // Model: a pending block blocks input; otherwise every offered word is taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); cur.delete();
      m_act = 1'b0; mfirst = 1'b0; merr = 1'b0;
    end else if (q.size() != 0) begin
      if (blk_ready) q.delete(0);
    end else if (in_valid) begin
      model_word();
    end
  end

  always @(posedge clk) begin
    blk_t c;
    if (rst_n && o_blk_valid && blk_ready) begin
      c.d = o_blk_data; c.f = o_blk_first; c.l = o_blk_last;
      cap.push_back(c);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst in_ready", o_in_ready, 1'b1);
      chk1("rst blk_valid", o_blk_valid, 1'b0);
      chk1("rst blk_first", o_blk_first, 1'b0);
      chk1("rst blk_last", o_blk_last, 1'b0);
      chk1("rst err", o_err, 1'b0);
      chk("rst blk_data", o_blk_data, '0);
    end else begin
      chk1("in_ready", o_in_ready, q.size() == 0);
      chk1("blk_valid", o_blk_valid, q.size() != 0);
      chk1("err", o_err, merr);
      if (q.size() != 0) begin
        chk("blk_data", o_blk_data, q[0].d);
        chk1("blk_first", o_blk_first, q[0].f);
        chk1("blk_last", o_blk_last, q[0].l);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    case (rmode)
      0:       blk_ready = 1'($urandom_range(0, 1));
      1:       blk_ready = 1'b1;
      default: blk_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [31:0] d, input logic h, input logic l, input logic [2:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_head = h; in_last = l; in_bytes = b;
    #1;
    while (!o_in_ready) begin
      if (t >= 300) begin
        n_cmp++; n_bad++;
        $display("FAIL send timeout: in_ready stuck low");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1; t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 400) begin @(negedge clk); t++; end
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain timeout: %0d blocks pending, expected 0", q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk1("async rst blk_valid", o_blk_valid, 1'b0);
    chk1("async rst in_ready", o_in_ready, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    string         s;
    logic [BW-1:0] e, snap;
    logic [31:0]   w;
    s = "The quick brown fox jumps over the lazy dog.";
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;

    // Fox message: 11 words then a tail-only word.
    rmode = 1; cap.delete();
    for (int i = 0; i < 11; i++)
      send({s[4*i], s[4*i+1], s[4*i+2], s[4*i+3]}, i == 0, 1'b0, 3'd4);
    send(32'h0, 1'b0, 1'b1, 3'd0);
    drain();
    chk("fox blocks", BW'(cap.size()), BW'(1));
    if (cap.size() == 1) begin
      chk("fox byte0", BW'(cap[0].d[7:0]), BW'(8'h54));
      chk("fox byte3", BW'(cap[0].d[31:24]), BW'(8'h20));
      chk("fox byte43", BW'(cap[0].d[8*43 +: 8]), BW'(8'h2E));
      chk("fox byte44", BW'(cap[0].d[8*44 +: 8]), BW'(8'h06));
      chk("fox byte71", BW'(cap[0].d[8*71 +: 8]), BW'(8'h80));
      chk("fox bytes45_70", BW'(cap[0].d[8*45 +: 8*26]), '0);
      chk1("fox first", cap[0].f, 1'b1);
      chk1("fox last", cap[0].l, 1'b1);
    end

    // Empty message.
    cap.delete();
    send(32'hDEADBEEF, 1'b1, 1'b1, 3'd0);
    drain();
    e = '0; e[7:0] = 8'h06; e[BW-1 -: 8] = 8'h80;
    chk("empty blocks", BW'(cap.size()), BW'(1));
    if (cap.size() == 1) begin
      chk("empty data", cap[0].d, e);
      chk1("empty first", cap[0].f, 1'b1);
      chk1("empty last", cap[0].l, 1'b1);
    end

    // 71 bytes: pad markers share byte 71.
    cap.delete();
    for (int i = 0; i < 17; i++) send($urandom, i == 0, 1'b0, 3'd4);
    send(32'h41424344, 1'b0, 1'b1, 3'd3);
    drain();
    chk("71B blocks", BW'(cap.size()), BW'(1));
    if (cap.size() == 1) begin
      chk("71B byte70", BW'(cap[0].d[8*70 +: 8]), BW'(8'h43));
      chk("71B byte71", BW'(cap[0].d[8*71 +: 8]), BW'(8'h86));
      chk1("71B last", cap[0].l, 1'b1);
    end

    // 72 bytes: data block then separate pad block.
    cap.delete();
    for (int i = 0; i < 17; i++) send($urandom, i == 0, 1'b0, 3'd4);
    send(32'hAABBCCDD, 1'b0, 1'b1, 3'd4);
    drain();
    chk("72B blocks", BW'(cap.size()), BW'(2));
    if (cap.size() == 2) begin
      chk("72B b1 byte71", BW'(cap[0].d[8*71 +: 8]), BW'(8'hDD));
      chk1("72B b1 first", cap[0].f, 1'b1);
      chk1("72B b1 last", cap[0].l, 1'b0);
      chk("72B b2 data", cap[1].d, e);
      chk1("72B b2 first", cap[1].f, 1'b0);
      chk1("72B b2 last", cap[1].l, 1'b1);
    end

    // Backpressure: held block, pending word goes to the next block.
    rmode = 2; cap.delete();
    for (int i = 0; i < 18; i++) send($urandom, i == 0, 1'b0, 3'd4);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hC0FFEE11; in_head = 1'b0; in_last = 1'b0; in_bytes = 3'd4;
    #1 snap = o_blk_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk1("bp in_ready", o_in_ready, 1'b0);
      chk("bp data stable", o_blk_data, snap);
    end
    rmode = 1;
    send(32'hC0FFEE11, 1'b0, 1'b0, 3'd4);
    send(32'h55667788, 1'b0, 1'b1, 3'd2);
    drain();
    chk("bp blocks", BW'(cap.size()), BW'(2));
    if (cap.size() == 2) begin
      chk("bp b2 byte0", BW'(cap[1].d[7:0]), BW'(8'hC0));
      chk("bp b2 byte6", BW'(cap[1].d[8*6 +: 8]), BW'(8'h06));
      chk1("bp b2 first", cap[1].f, 1'b0);
    end

    // Reset mid-FILL, then a stray word sets err, and a head clears it.
    for (int i = 0; i < 5; i++) send($urandom, i == 0, 1'b0, 3'd4);
    do_reset();
    send(32'h11223344, 1'b0, 1'b0, 3'd4);
    @(negedge clk); #1;
    chk1("err set", o_err, 1'b1);
    send(32'h99887766, 1'b1, 1'b1, 3'd1);
    @(negedge clk); #1;
    chk1("err cleared", o_err, 1'b0);
    drain();

    // Reset mid-FULL.
    rmode = 2;
    for (int i = 0; i < 18; i++) send($urandom, i == 0, 1'b0, 3'd4);
    do_reset();
    rmode = 1;

    // Randomized traffic.
    rmode = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r >= 95) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (i == 250) begin
        do_reset();
      end
      send($urandom, r < 8, $urandom_range(0, 11) == 0, 3'($urandom_range(0, 7)));
    end
    send($urandom, 1'b1, 1'b1, 3'd4);
    rmode = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
